// File: rtl/fp_pkg.sv
// Shared widths, saturation exponent and normalizer state encoding for the FP datapath.
package fp_pkg;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_e;

endpackage

// File: rtl/fp_normalizer.sv
// Sequential post-add normalizer: one left shift per cycle until the hidden bit is set,
// with carry renormalization, zero/overflow/underflow detection and special passthrough.
module fp_normalizer
  import fp_pkg::*;
#(
  parameter int MANT_W = fp_pkg::MANT_W,
  parameter int EXP_W  = fp_pkg::EXP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MANT_W-1:0] mant_in,
  input  logic              carry_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              busy,
  output logic              done,
  output logic [MANT_W-2:0] frac_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              zero,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [EXP_W-1:0] EXP_SAT = '1;

  norm_state_e       state;
  logic [MANT_W-1:0] mant_r;
  logic [EXP_W-1:0]  exp_r;
  logic              carry_r;
  logic [EXP_W-1:0]  exp_inc;

  assign exp_inc = exp_r + 1'b1;

  // Working registers shift during NORM; the visible outputs only change on the finishing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mant_r    <= '0;
      exp_r     <= '0;
      carry_r   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frac_out  <= '0;
      exp_out   <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mant_r    <= mant_in;
            carry_r   <= carry_in;
            exp_r     <= exp_in;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            busy      <= 1'b1;
            state     <= NORM;
          end
        end
        NORM: begin
          if (exp_r == EXP_SAT) begin
            frac_out <= mant_r[MANT_W-2:0];
            exp_out  <= exp_r;
            done     <= 1'b1;
            state    <= DONE;
          end else if (carry_r) begin
            carry_r <= 1'b0;
            exp_r   <= exp_inc;
            exp_out <= exp_inc;
            if (exp_inc == EXP_SAT) begin
              mant_r   <= '0;
              frac_out <= '0;
              overflow <= 1'b1;
            end else begin
              mant_r   <= {1'b1, mant_r[MANT_W-1:1]};
              frac_out <= mant_r[MANT_W-1:1];
            end
            done  <= 1'b1;
            state <= DONE;
          end else if (mant_r == '0) begin
            exp_r    <= '0;
            frac_out <= '0;
            exp_out  <= '0;
            zero     <= 1'b1;
            done     <= 1'b1;
            state    <= DONE;
          end else if (mant_r[MANT_W-1]) begin
            frac_out <= mant_r[MANT_W-2:0];
            exp_out  <= exp_r;
            done     <= 1'b1;
            state    <= DONE;
          end else if (exp_r == '0) begin
            frac_out  <= mant_r[MANT_W-2:0];
            exp_out   <= '0;
            underflow <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            mant_r <= {mant_r[MANT_W-2:0], 1'b0};
            exp_r  <= exp_r - 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed bench for fp_normalizer: closed-form result/latency model checked every cycle,
// plus literal expectations for the documented scenarios and boundaries.
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] mant_in = '0;
  logic        carry_in = 1'b0;
  logic [7:0]  exp_in = '0;
  logic        busy, done, zero, overflow, underflow;
  logic [22:0] frac_out;
  logic [7:0]  exp_out;

  int nvec = 0;
  int nerr = 0;

  fp_normalizer #(.MANT_W(24), .EXP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mant_in(mant_in), .carry_in(carry_in),
    .exp_in(exp_in), .busy(busy), .done(done), .frac_out(frac_out), .exp_out(exp_out),
    .zero(zero), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  typedef struct {
    logic [22:0] frac;
    logic [7:0]  e;
    logic        z, o, u;
    int          lat;
  } res_t;

  // Closed-form outcome: count leading zeros once, then decide how far the exponent allows shifting.
  function automatic res_t model(input logic [23:0] m, input logic c, input logic [7:0] e);
    res_t r;
    int lz;
    logic [23:0] sh;
    r.frac = '0; r.e = '0; r.z = 1'b0; r.o = 1'b0; r.u = 1'b0; r.lat = 1;
    if (e == 8'hFF) begin
      r.frac = m[22:0]; r.e = e;
    end else if (c) begin
      if (int'(e) + 1 == 255) begin
        r.o = 1'b1; r.e = 8'hFF;
      end else begin
        r.frac = m[23:1]; r.e = e + 8'd1;
      end
    end else if (m == 24'd0) begin
      r.z = 1'b1;
    end else begin
      lz = 0;
      while (!m[23-lz]) lz++;
      if (lz <= int'(e)) begin
        sh = m << lz;
        r.frac = sh[22:0]; r.e = e - 8'(lz); r.lat = lz + 1;
      end else begin
        sh = m << e;
        r.frac = sh[22:0]; r.u = 1'b1; r.lat = int'(e) + 1;
      end
    end
    return r;
  endfunction

  logic        m_busy = 0, m_done = 0, m_z = 0, m_o = 0, m_u = 0;
  logic [22:0] m_frac = '0;
  logic [7:0]  m_exp = '0;
  int          m_cnt = 0;
  res_t        pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_z = 0; m_o = 0; m_u = 0; m_frac = '0; m_exp = '0; m_cnt = 0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1; m_frac = pend.frac; m_exp = pend.e; m_z = pend.z; m_o = pend.o; m_u = pend.u;
      end
    end else if (start) begin
      pend = model(mant_in, carry_in, exp_in);
      m_cnt = pend.lat; m_busy = 1; m_z = 0; m_o = 0; m_u = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("frac_out", 32'(frac_out), 32'(m_frac));
      check("exp_out", 32'(exp_out), 32'(m_exp));
      check("zero", 32'(zero), 32'(m_z));
      check("overflow", 32'(overflow), 32'(m_o));
      check("underflow", 32'(underflow), 32'(m_u));
    end
  end

  task automatic wait_done(input string name, output int lat);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    if (lat == 0) check({name, " timeout"}, 32'(0), 32'(1));
  endtask

  task automatic run_op(input string name, input logic [23:0] m, input logic c, input logic [7:0] e,
                        input int lat_r, input logic [22:0] f_r, input logic [7:0] e_r,
                        input logic z_r, input logic o_r, input logic u_r);
    int lat;
    @(negedge clk);
    mant_in = m; carry_in = c; exp_in = e; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(name, lat);
    check({name, " latency"}, 32'(lat), 32'(lat_r));
    check({name, " frac"}, 32'(frac_out), 32'(f_r));
    check({name, " exp"}, 32'(exp_out), 32'(e_r));
    check({name, " flags"}, 32'({zero, overflow, underflow}), 32'({z_r, o_r, u_r}));
    repeat (2) @(posedge clk);
  endtask

  task automatic expect_cleared(input string name);
    check({name, " busy/done"}, 32'({busy, done}), 32'(0));
    check({name, " frac"}, 32'(frac_out), 32'(0));
    check({name, " exp"}, 32'(exp_out), 32'(0));
    check({name, " flags"}, 32'({zero, overflow, underflow}), 32'(0));
  endtask

  initial begin
    int lat;
    #1 expect_cleared("reset");
    #20 rst_n = 1'b1;

    run_op("normalized",  24'h800000, 1'b0, 8'd127, 1,  23'h0,      8'd127, 0, 0, 0);
    run_op("lz23",        24'h000001, 1'b0, 8'd127, 24, 23'h0,      8'd104, 0, 0, 0);
    run_op("carry_ovf",   24'h000000, 1'b1, 8'd254, 1,  23'h0,      8'd255, 0, 1, 0);
    run_op("zero",        24'h000000, 1'b0, 8'd50,  1,  23'h0,      8'd0,   1, 0, 0);
    run_op("underflow",   24'h000100, 1'b0, 8'd3,   4,  23'h000800, 8'd0,   0, 0, 1);
    run_op("special",     24'h123456, 1'b0, 8'd255, 1,  23'h123456, 8'd255, 0, 0, 0);
    run_op("special_cy",  24'h000000, 1'b1, 8'd255, 1,  23'h0,      8'd255, 0, 0, 0);
    run_op("carry",       24'hC00001, 1'b1, 8'd10,  1,  23'h600000, 8'd11,  0, 0, 0);
    run_op("lz_eq_exp",   24'h000100, 1'b0, 8'd15,  16, 23'h0,      8'd0,   0, 0, 0);
    run_op("exp0_norm",   24'h800001, 1'b0, 8'd0,   1,  23'h000001, 8'd0,   0, 0, 0);
    run_op("exp0_denorm", 24'h000001, 1'b0, 8'd0,   1,  23'h000001, 8'd0,   0, 0, 1);

    // start pulsed mid-NORM and again during DONE must both be ignored
    @(negedge clk);
    mant_in = 24'h000001; carry_in = 1'b0; exp_in = 8'd127; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 mant_in = 24'h800000; exp_in = 8'd10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("busy_ign", lat);
    check("busy_ign latency", 32'(lat), 32'(21));
    check("busy_ign exp", 32'(exp_out), 32'(104));
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("done_ign busy", 32'({busy, done}), 32'(0));
    @(posedge clk); #1;
    check("done_ign idle", 32'({busy, done}), 32'(0));

    // asynchronous reset mid-operation
    @(negedge clk);
    mant_in = 24'h000001; exp_in = 8'd127; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 expect_cleared("async_rst");
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin
        @(negedge clk); #2 rst_n = 1'b1;
      end
      if (done) check("no_done_after_rst", 32'(done), 32'(0));
    end
    check("post_rst idle", 32'({busy, done}), 32'(0));

    run_op("after_rst",   24'h800000, 1'b0, 8'd127, 1,  23'h0,      8'd127, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule

// File: doc/fp_normalizer.md
FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 SHALL have parameter MANT_W, default 24, meaning the mantissa width including the hidden bit.
REQ-002 SHALL have parameter EXP_W, default 8, meaning the biased exponent width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: load the operand and begin normalization.
REQ-006 SHALL have port mant_in, input, MANT_W bits: raw mantissa from the upstream 24-bit select mux.
REQ-007 SHALL have port carry_in, input, 1 bit: mantissa carry-out from the adder.
REQ-008 SHALL have port exp_in, input, EXP_W bits: biased exponent.
REQ-009 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-011 SHALL have port frac_out, output, MANT_W-1 bits: normalized fraction with the hidden bit dropped.
REQ-012 SHALL have port exp_out, output, EXP_W bits: adjusted exponent.
REQ-013 SHALL have ports zero, overflow and underflow, output, 1 bit each: result status flags.

Function
REQ-014 SHALL implement states IDLE, NORM and DONE.
REQ-015 In IDLE, start=1 at an edge SHALL load mant_in, carry_in and exp_in into internal registers, clear all flags, and move to NORM.
REQ-016 start SHALL be ignored while busy=1.
REQ-017 busy SHALL be 1 in NORM and DONE and 0 in IDLE.
REQ-018 In NORM, SHALL evaluate the following rules in priority order, one rule per edge; the rules that finish an operation move to DONE.
REQ-019 Rule (a): if exp=all-ones (special value), SHALL hold mantissa and exponent unchanged and move to DONE.
REQ-020 Rule (b): if carry=1, SHALL set mant={1,mant[MANT_W-1:1]}, set exp+1, clear carry, and move to DONE.
REQ-021 Rule (b) overflow: if the incremented exponent equals all-ones, SHALL set overflow=1 and mant=0, giving infinity.
REQ-022 Rule (c): if mant=0, SHALL set zero=1, exp=0 and move to DONE.
REQ-023 Rule (d): if mant[MANT_W-1]=1, SHALL move to DONE.
REQ-024 Rule (e): if exp=0, SHALL set underflow=1, keep the mantissa as a denormal, and move to DONE.
REQ-025 Rule (f): otherwise SHALL set mant=mant<<1 and exp-1, and remain in NORM.
REQ-026 Latency: with k leading zeros (k≥1, no carry), done SHALL follow the (k+1)th edge after the start edge; carry, normalized, zero and special inputs SHALL take 1 edge.
REQ-027 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-028 A start asserted during DONE SHALL be ignored.
REQ-029 frac_out, exp_out and the flags SHALL be driven from registers and SHALL hold their values from DONE until the next accepted start.
REQ-030 Exponent arithmetic SHALL be unsigned EXP_W-bit and SHALL never wrap: rule (e) precedes any decrement and REQ-021 caps the increment.

Reset
REQ-031 While rst_n=0, SHALL immediately force state=IDLE, busy=0, done=0, frac_out=0, exp_out=0 and all flags=0, independent of clk.
REQ-032 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-033 The first start accepted after rst_n rises SHALL behave as from power-up.

Structure
REQ-034 Shared package fp_pkg SHALL hold MANT_W, EXP_W, EXP_MAX (all-ones exponent) and the normalizer state encoding.
REQ-035 The block SHALL be a single module; the upstream 24-bit mux SHALL be instantiated by the parent, not inside this block.
REQ-036 Leading-zero counting SHALL be sequential (one shift per cycle); no priority-encoder sub-module is required.

Verification
REQ-037 Scenario: mant_in=24'h800000, carry=0, exp=127 -> done after 1 edge; frac_out=0, exp_out=127, all flags 0.
REQ-038 Scenario: mant_in=24'h000001, exp=127 -> done after 24 edges; frac_out=0, exp_out=104.
REQ-039 Scenario: carry=1, mant_in=24'h000000, exp=254 -> overflow=1, exp_out=255, frac_out=0.
REQ-040 Scenario: mant_in=24'h000000, exp=50 -> zero=1, exp_out=0, done after 1 edge.
REQ-041 Scenario: mant_in=24'h000100, exp=3 -> underflow=1, exp_out=0, frac_out=23'h000800.
REQ-042 Scenario: start with mant_in=24'h000001, then rst_n=0 after 5 cycles -> outputs cleared immediately, no done pulse; a second start pulsed while busy=1 is ignored.
